// File: rtl/lcd_timing_gen.sv
// Pixel/line timing generator for a 480x272 LCD panel, with warm-up, run and
// end-of-frame shutdown sequencing. All outputs are registered and cycle-aligned.
module lcd_timing_gen #(
    parameter int H_SYNC         = 41,
    parameter int H_BACK         = 2,
    parameter int H_ACTIVE       = 480,
    parameter int H_FRONT        = 2,
    parameter int V_SYNC         = 10,
    parameter int V_BACK         = 2,
    parameter int V_ACTIVE       = 272,
    parameter int V_FRONT        = 2,
    parameter int POWERUP_FRAMES = 4
) (
    input  logic       clk9MHz,
    input  logic       resetn,
    input  logic       enable,
    output logic [9:0] vgaCount,
    output logic [8:0] lineCount,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       de,
    output logic       start,
    output logic       frameTick,
    output logic [1:0] fsm_state
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_END   = 10'(H_SYNC);
    localparam logic [9:0] HV_BEGIN = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HV_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] VS_END   = 9'(V_SYNC);
    localparam logic [8:0] VV_BEGIN = 9'(V_SYNC + V_BACK);
    localparam logic [8:0] VV_END   = 9'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [7:0] PU_FRAMES = 8'(POWERUP_FRAMES);

    typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    state_t     state, state_nxt;
    logic [7:0] frames, frames_nxt, frames_inc;
    logic [9:0] h_nxt;
    logic [8:0] v_nxt;
    logic       run_nxt, vis_nxt;

    assign fsm_state = state;

    // Everything registered below is derived from the next-cycle counter and
    // state values, so the decodes line up with the counters they describe.
    always_comb begin
        state_nxt  = state;
        frames_nxt = frames;
        frames_inc = (frames == 8'hFF) ? frames : frames + 8'd1;
        h_nxt      = (vgaCount == H_LAST) ? 10'd0 : vgaCount + 10'd1;
        v_nxt      = lineCount;
        if (vgaCount == H_LAST) begin
            v_nxt = (lineCount == V_LAST) ? 9'd0 : lineCount + 9'd1;
        end

        case (state)
            IDLE: begin
                if (enable) state_nxt = WARMUP;
            end
            WARMUP: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (frameTick) begin
                    frames_nxt = frames_inc;
                    if (frames_inc >= PU_FRAMES) state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Shutdown completes on the frame boundary even if enable returns then.
                if (frameTick) state_nxt = IDLE;
                else if (enable) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase

        // IDLE (held or entered) parks counters at the origin and forgets warm-up progress.
        if (state == IDLE || state_nxt == IDLE) begin
            h_nxt      = 10'd0;
            v_nxt      = 9'd0;
            frames_nxt = 8'd0;
        end

        run_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
        vis_nxt = (h_nxt >= HV_BEGIN) && (h_nxt < HV_END) &&
                  (v_nxt >= VV_BEGIN) && (v_nxt < VV_END);
    end

    always_ff @(posedge clk9MHz or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            frames    <= 8'd0;
            vgaCount  <= 10'd0;
            lineCount <= 9'd0;
            hsync_n   <= 1'b1;
            vsync_n   <= 1'b1;
            de        <= 1'b0;
            start     <= 1'b0;
            frameTick <= 1'b0;
        end else begin
            state     <= state_nxt;
            frames    <= frames_nxt;
            vgaCount  <= h_nxt;
            lineCount <= v_nxt;
            hsync_n   <= (state_nxt == IDLE) || (h_nxt >= HS_END);
            vsync_n   <= (state_nxt == IDLE) || (v_nxt >= VS_END);
            start     <= run_nxt;
            de        <= run_nxt && vis_nxt;
            frameTick <= (state_nxt != IDLE) && (h_nxt == H_LAST) && (v_nxt == V_LAST);
        end
    end

endmodule
